// File: rtl/timer_bank.sv
// timer_bank: N_CH programmable one-shot / auto-reload / free-run timers
// behind a word-mapped register file, with a registered, maskable IRQ.
module timer_bank #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] M_AUTO = 2'b01;
    localparam logic [1:0] M_FREE = 2'b10;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [3:0] a_blk;
    logic [1:0] a_wrd;
    logic       gwr;
    logic       unused_bits;

    assign a_blk       = Addr[7:4];
    assign a_wrd       = Addr[3:2];
    assign gwr         = WE && (a_blk == 4'hF);
    assign unused_bits = ^{Addr[31:8], Din};

    logic [N_CH-1:0]            pend_q, pend_d;
    logic [N_CH-1:0]            mask_q, mask_d;
    logic [N_CH-1:0]            clr;
    logic [N_CH-1:0]            hit;
    logic                       irq_q;
    logic [N_CH-1:0][CNT_W-1:0] pre_v;
    logic [N_CH-1:0][CNT_W-1:0] cnt_v;
    logic [N_CH-1:0][2:0]       ctrl_v;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [1:0]       st_q, st_d;
        logic [1:0]       mode_q, mode_d;
        logic             en_q, en_d;
        logic [CNT_W-1:0] pre_q, pre_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             sel, ctrl_wr, hit_c;

        assign sel     = WE && (a_blk == 4'(c));
        assign ctrl_wr = sel && (a_wrd == 2'd0);

        always_comb begin
            st_d   = st_q;
            en_d   = en_q;
            mode_d = mode_q;
            pre_d  = pre_q;
            cnt_d  = cnt_q;
            hit_c  = 1'b0;
            unique case (st_q)
                S_IDLE: if (en_q) st_d = S_LOAD;
                S_LOAD: begin
                    cnt_d = (mode_q == M_FREE) ? '0 : pre_q;
                    st_d  = S_CNT;
                end
                S_CNT: begin
                    if (mode_q == M_FREE) begin
                        cnt_d = cnt_q + ONE;
                    end else if (cnt_q > ONE) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        cnt_d = '0;
                        hit_c = 1'b1;
                        st_d  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (mode_q == M_AUTO) begin
                        st_d = S_LOAD;
                    end else begin
                        st_d = S_IDLE;
                        en_d = 1'b0;
                    end
                end
            endcase
            // A stop write freezes the channel where it stands.
            if (ctrl_wr) begin
                en_d   = Din[0];
                mode_d = Din[2:1];
                if (!Din[0]) begin
                    st_d  = S_IDLE;
                    cnt_d = cnt_q;
                    hit_c = 1'b0;
                end
            end
            if (sel && (a_wrd == 2'd1)) pre_d = Din[CNT_W-1:0];
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                st_q   <= S_IDLE;
                en_q   <= 1'b0;
                mode_q <= 2'b00;
                pre_q  <= '0;
                cnt_q  <= '0;
            end else begin
                st_q   <= st_d;
                en_q   <= en_d;
                mode_q <= mode_d;
                pre_q  <= pre_d;
                cnt_q  <= cnt_d;
            end
        end

        assign hit[c]    = hit_c;
        assign pre_v[c]  = pre_q;
        assign cnt_v[c]  = cnt_q;
        assign ctrl_v[c] = {mode_q, en_q};
    end

    // Hardware set wins over a coincident W1C.
    always_comb begin
        clr    = (gwr && (a_wrd == 2'd0)) ? Din[N_CH-1:0] : '0;
        pend_d = (pend_q & ~clr) | hit;
        mask_d = (gwr && (a_wrd == 2'd1)) ? Din[N_CH-1:0] : mask_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            irq_q  <= |(pend_q & mask_q);
        end
    end

    assign IRQ = irq_q;

    always_comb begin
        Dout = '0;
        if (a_blk == 4'hF) begin
            if (a_wrd == 2'd0) Dout[N_CH-1:0] = pend_q;
            else if (a_wrd == 2'd1) Dout[N_CH-1:0] = mask_q;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (a_blk == 4'(c)) begin
                case (a_wrd)
                    2'd0:    Dout[2:0]       = ctrl_v[c];
                    2'd1:    Dout[CNT_W-1:0] = pre_v[c];
                    2'd2:    Dout[CNT_W-1:0] = cnt_v[c];
                    default: Dout            = '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed vectors for timer_bank (N_CH=2, CNT_W=8)
// with hand-computed expectations.
module tb_timer_bank;
    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] CTRL0 = 32'h00;
    localparam logic [31:0] PRE0  = 32'h04;
    localparam logic [31:0] CNT0  = 32'h08;
    localparam logic [31:0] CTRL1 = 32'h10;
    localparam logic [31:0] PRE1  = 32'h14;
    localparam logic [31:0] CNT1  = 32'h18;
    localparam logic [31:0] STAT  = 32'hF0;
    localparam logic [31:0] MASK  = 32'hF4;

    timer_bank #(.N_CH(2), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] a,
                          input logic [31:0] exp);
        Addr = a[31:2];
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a[31:2];
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        step(3);
        reset = 1'b1;
        chk_rd("rst_ctrl0", CTRL0, 32'h0);
        chk_rd("rst_pre0", PRE0, 32'h0);
        chk_rd("rst_cnt0", CNT0, 32'h0);
        chk_rd("rst_stat", STAT, 32'h0);
        chk_rd("rst_mask", MASK, 32'h0);
        chk("rst_irq", {31'b0, IRQ}, 32'h0);

        // one-shot, preset 3
        wr(MASK, 32'h1);
        wr(PRE0, 32'h3);
        wr(CTRL0, 32'h1);
        step(2);
        chk_rd("os_cnt3", CNT0, 32'd3);
        step(1);
        chk_rd("os_cnt2", CNT0, 32'd2);
        step(1);
        chk_rd("os_cnt1", CNT0, 32'd1);
        chk_rd("os_stat_lo", STAT, 32'h0);
        step(1);
        chk_rd("os_cnt0", CNT0, 32'd0);
        chk_rd("os_stat_hi", STAT, 32'h1);
        chk("os_irq_lag", {31'b0, IRQ}, 32'h0);
        step(1);
        chk("os_irq", {31'b0, IRQ}, 32'h1);
        chk_rd("os_ctrl_clr", CTRL0, 32'h0);
        wr(STAT, 32'h1);
        chk_rd("os_w1c", STAT, 32'h0);
        step(1);
        chk("os_irq_off", {31'b0, IRQ}, 32'h0);

        // auto-reload on channel 1, preset 2
        wr(PRE1, 32'h2);
        wr(CTRL1, 32'h3);
        step(3);
        chk_rd("ar_stat0", STAT, 32'h0);
        step(1);
        chk_rd("ar_stat1", STAT, 32'h2);
        wr(STAT, 32'h2);
        chk_rd("ar_w1c", STAT, 32'h0);
        step(1);
        chk_rd("ar_reload", CNT1, 32'd2);
        step(1);
        wr(STAT, 32'h2);
        chk_rd("ar_set_wins", STAT, 32'h2);
        chk("ar_irq_masked", {31'b0, IRQ}, 32'h0);
        wr(CTRL1, 32'h0);
        wr(STAT, 32'h3);
        chk_rd("ar_stat_clr", STAT, 32'h0);

        // unmapped / reserved reads
        chk_rd("rsvd_w3", 32'h0C, 32'h0);
        chk_rd("no_ch2", 32'h20, 32'h0);
        chk_rd("rsvd_f8", 32'hF8, 32'h0);

        // stop at 5, then restart reloads from preset
        wr(PRE0, 32'd20);
        wr(CTRL0, 32'h1);
        step(17);
        chk_rd("sr_at5", CNT0, 32'd5);
        wr(CTRL0, 32'h0);
        chk_rd("sr_frz", CNT0, 32'd5);
        step(3);
        chk_rd("sr_hold", CNT0, 32'd5);
        chk_rd("sr_ctrl", CTRL0, 32'h0);
        wr(CTRL0, 32'h1);
        step(2);
        chk_rd("sr_reload", CNT0, 32'd20);
        wr(CTRL0, 32'h0);
        chk_rd("sr_no_pend", STAT, 32'h0);

        // free-run wraps at 2^8
        wr(CTRL0, 32'h5);
        step(2);
        chk_rd("fr_0", CNT0, 32'd0);
        step(255);
        chk_rd("fr_255", CNT0, 32'd255);
        step(1);
        chk_rd("fr_wrap", CNT0, 32'd0);
        chk_rd("fr_no_pend", STAT, 32'h0);
        wr(CTRL0, 32'h0);

        // simultaneous expiry, channel 1 masked
        wr(PRE0, 32'd4);
        wr(PRE1, 32'd3);
        wr(CTRL0, 32'h1);
        wr(CTRL1, 32'h1);
        step(5);
        chk_rd("mk_both", STAT, 32'h3);
        step(1);
        chk("mk_irq", {31'b0, IRQ}, 32'h1);
        wr(STAT, 32'h1);
        chk_rd("mk_stat2", STAT, 32'h2);
        step(1);
        chk("mk_irq_off", {31'b0, IRQ}, 32'h0);
        wr(STAT, 32'h2);
        wr(MASK, 32'hFF);
        chk_rd("mk_width", MASK, 32'h3);

        // reset mid-count with a concurrent CTRL write
        wr(PRE0, 32'd20);
        wr(CTRL0, 32'h1);
        step(15);
        chk_rd("rm_at7", CNT0, 32'd7);
        reset = 1'b0;
        Addr  = CTRL0[31:2];
        Din   = 32'h3;
        WE    = 1'b1;
        step(1);
        reset = 1'b1;
        WE    = 1'b0;
        chk_rd("rm_ctrl", CTRL0, 32'h0);
        chk_rd("rm_cnt", CNT0, 32'h0);
        chk_rd("rm_pre", PRE0, 32'h0);
        chk_rd("rm_mask", MASK, 32'h0);
        chk("rm_irq", {31'b0, IRQ}, 32'h0);
        step(5);
        chk_rd("rm_idle", STAT, 32'h0);
        chk_rd("rm_cnt_idle", CNT0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
